// File: rtl/keypad_guess_entry.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : keypad_guess_entry
// Description : 4x4 keypad scanner/debouncer feeding a two-digit BCD guess
//               entry FSM with a one-clock Load strobe for the game core.
// Revision    : 1.0 - initial release
// ============================================================================
module keypad_guess_entry #(
  parameter int SCAN_DIV        = 25000,
  parameter int DEBOUNCE_FRAMES = 5
) (
  input  logic       CLK,
  input  logic       Reset,
  input  logic [3:0] Col,
  output logic [3:0] Row,
  output logic [3:0] Data_out_ten_digit,
  output logic [3:0] Data_out_unit_digit,
  output logic       Load,
  output logic [1:0] Digit_cnt,
  output logic       Key_valid,
  output logic [3:0] Key_code
);

  localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int DB_W  = $clog2(DEBOUNCE_FRAMES + 1);
  localparam logic [DIV_W-1:0] c_DIV_LAST  = DIV_W'(SCAN_DIV - 1);
  localparam logic [DB_W-1:0]  c_DB_TARGET = DB_W'(DEBOUNCE_FRAMES);
  localparam logic [3:0]       c_KEY_B     = 4'hB;
  localparam logic [3:0]       c_KEY_E     = 4'hE;
  localparam logic [3:0]       c_KEY_F     = 4'hF;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  function automatic logic [3:0] f_key_map(input logic [1:0] row, input logic [1:0] col);
    logic [3:0] k;
    case ({row, col})
      4'h0: k = 4'h1;  4'h1: k = 4'h2;  4'h2: k = 4'h3;  4'h3: k = 4'hA;
      4'h4: k = 4'h4;  4'h5: k = 4'h5;  4'h6: k = 4'h6;  4'h7: k = 4'hB;
      4'h8: k = 4'h7;  4'h9: k = 4'h8;  4'hA: k = 4'h9;  4'hB: k = 4'hC;
      4'hC: k = 4'hE;  4'hD: k = 4'h0;  4'hE: k = 4'hF;  default: k = 4'hD;
    endcase
    return k;
  endfunction

  logic [3:0]       r_col_meta;
  logic [3:0]       r_col_sync;
  logic [DIV_W-1:0] r_div;
  logic [1:0]       r_row_idx;
  logic [3:0]       r_row;
  logic [1:0]       r_frame_hits;
  logic [3:0]       r_frame_key;
  logic [4:0]       r_prev_res;
  logic [4:0]       r_db_state;
  logic [DB_W-1:0]  r_db_cnt;
  logic             r_key_valid;
  logic [3:0]       r_key_code;
  state_t           r_state;
  logic [3:0]       r_ten;
  logic [3:0]       r_unit;
  logic             r_load;

  logic             w_dwell_end;
  logic             w_frame_end;
  logic [1:0]       w_idx_nxt;
  logic [2:0]       w_row_hits;
  logic [1:0]       w_row_col;
  logic [3:0]       w_row_code;
  logic [2:0]       w_sum_hits;
  logic [1:0]       w_hits_sat;
  logic [4:0]       w_res;
  logic [DB_W-1:0]  w_cnt_nxt;
  logic             w_db_hit;
  logic             w_accept;
  state_t           w_state_nxt;
  logic [3:0]       w_ten_nxt;
  logic [3:0]       w_unit_nxt;
  logic             w_load_nxt;

  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      r_col_meta <= 4'hF;
      r_col_sync <= 4'hF;
    end else begin
      r_col_meta <= Col;
      r_col_sync <= r_col_meta;
    end
  end

  assign w_dwell_end = (r_div == c_DIV_LAST);
  assign w_frame_end = w_dwell_end && (r_row_idx == 2'd3);
  assign w_idx_nxt   = r_row_idx + 2'd1;

  always_comb begin
    w_row_hits = '0;
    w_row_col  = '0;
    for (int c = 0; c < 4; c++) begin
      if (!r_col_sync[c]) begin
        w_row_hits = w_row_hits + 3'd1;
        w_row_col  = 2'(c);
      end
    end
  end

  assign w_row_code = f_key_map(r_row_idx, w_row_col);
  assign w_sum_hits = {1'b0, r_frame_hits} + w_row_hits;
  assign w_hits_sat = (w_sum_hits > 3'd1) ? 2'd2 : w_sum_hits[1:0];

  // Result is {valid, code}; all-zero stands for NONE (no key or ghosted).
  always_comb begin
    w_res = 5'b0;
    if (w_sum_hits == 3'd1) begin
      w_res = {1'b1, (r_frame_hits == 2'd0) ? w_row_code : r_frame_key};
    end
  end

  assign w_cnt_nxt = (w_res != r_prev_res)     ? DB_W'(1) :
                     (r_db_cnt == c_DB_TARGET) ? r_db_cnt : r_db_cnt + DB_W'(1);
  assign w_db_hit  = (w_cnt_nxt == c_DB_TARGET);
  assign w_accept  = w_frame_end && w_db_hit && !r_db_state[4] && w_res[4];

  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      r_div        <= '0;
      r_row_idx    <= '0;
      r_row        <= 4'b1110;
      r_frame_hits <= '0;
      r_frame_key  <= '0;
    end else if (w_dwell_end) begin
      r_div     <= '0;
      r_row_idx <= w_idx_nxt;
      r_row     <= ~(4'b0001 << w_idx_nxt);
      if (w_frame_end) begin
        r_frame_hits <= '0;
      end else begin
        r_frame_hits <= w_hits_sat;
        if (w_row_hits == 3'd1 && r_frame_hits == 2'd0) r_frame_key <= w_row_code;
      end
    end else begin
      r_div <= r_div + DIV_W'(1);
    end
  end

  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      r_prev_res  <= '0;
      r_db_state  <= '0;
      r_db_cnt    <= '0;
      r_key_valid <= 1'b0;
      r_key_code  <= '0;
    end else begin
      r_key_valid <= w_accept;
      if (w_accept) r_key_code <= w_res[3:0];
      if (w_frame_end) begin
        r_prev_res <= w_res;
        r_db_cnt   <= w_cnt_nxt;
        if (w_db_hit) r_db_state <= w_res;
      end
    end
  end

  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      r_state <= EMPTY;
      r_ten   <= '0;
      r_unit  <= '0;
      r_load  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_ten   <= w_ten_nxt;
      r_unit  <= w_unit_nxt;
      r_load  <= w_load_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_ten_nxt   = r_ten;
    w_unit_nxt  = r_unit;
    w_load_nxt  = 1'b0;
    if (r_key_valid) begin
      if (r_key_code <= 4'd9) begin
        case (r_state)
          EMPTY: begin
            w_unit_nxt  = r_key_code;
            w_ten_nxt   = '0;
            w_state_nxt = ONE;
          end
          ONE: begin
            w_ten_nxt   = r_unit;
            w_unit_nxt  = r_key_code;
            w_state_nxt = TWO;
          end
          default: ;
        endcase
      end else if (r_key_code == c_KEY_F) begin
        // Digits stay on the outputs after Load; only the count clears.
        if (r_state != EMPTY) begin
          w_load_nxt  = 1'b1;
          w_state_nxt = EMPTY;
        end
      end else if (r_key_code == c_KEY_E) begin
        w_ten_nxt   = '0;
        w_unit_nxt  = '0;
        w_state_nxt = EMPTY;
      end else if (r_key_code == c_KEY_B) begin
        case (r_state)
          TWO: begin
            w_unit_nxt  = r_ten;
            w_ten_nxt   = '0;
            w_state_nxt = ONE;
          end
          ONE: begin
            w_unit_nxt  = '0;
            w_ten_nxt   = '0;
            w_state_nxt = EMPTY;
          end
          default: ;
        endcase
      end
    end
  end

  assign Row                 = r_row;
  assign Data_out_ten_digit  = r_ten;
  assign Data_out_unit_digit = r_unit;
  assign Load                = r_load;
  assign Digit_cnt           = r_state;
  assign Key_valid           = r_key_valid;
  assign Key_code            = r_key_code;

endmodule
`default_nettype wire

// File: tb/tb_keypad_guess_entry.sv
`timescale 1ns/1ps
`default_nettype none
// Bench for keypad_guess_entry: switch-matrix keypad model plus a digit-list
// reference model of the guess entry behaviour.
module tb_keypad_guess_entry;

  localparam int FRAME = 16;

  logic       CLK = 1'b0;
  logic       Reset = 1'b0;
  logic [3:0] Col;
  logic [3:0] Row;
  logic [3:0] Data_out_ten_digit;
  logic [3:0] Data_out_unit_digit;
  logic       Load;
  logic [1:0] Digit_cnt;
  logic       Key_valid;
  logic [3:0] Key_code;

  keypad_guess_entry #(.SCAN_DIV(4), .DEBOUNCE_FRAMES(2)) dut (
    .CLK                (CLK),
    .Reset              (Reset),
    .Col                (Col),
    .Row                (Row),
    .Data_out_ten_digit (Data_out_ten_digit),
    .Data_out_unit_digit(Data_out_unit_digit),
    .Load               (Load),
    .Digit_cnt          (Digit_cnt),
    .Key_valid          (Key_valid),
    .Key_code           (Key_code)
  );

  always #5 CLK = ~CLK;

  // Switch closed at index r*4+c pulls column c low whenever row r is driven low.
  logic [15:0] sw = '0;
  always_comb begin
    Col = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (sw[r*4+c] && !Row[r]) Col[c] = 1'b0;
  end

  logic [3:0] kmap [16] = '{4'h1, 4'h2, 4'h3, 4'hA,
                            4'h4, 4'h5, 4'h6, 4'hB,
                            4'h7, 4'h8, 4'h9, 4'hC,
                            4'hE, 4'h0, 4'hF, 4'hD};

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Reference model: the guess is a list of at most two entered digits.
  int         ent[$];
  logic [3:0] m_ten = 0, m_unit = 0, exp_code = 0;
  int         exp_kv = 0, exp_loads = 0;
  logic [3:0] exp_ld_ten = 0, exp_ld_unit = 0;

  function automatic void refresh();
    m_ten  = (ent.size() == 2) ? 4'(ent[0]) : 4'd0;
    m_unit = (ent.size() >= 1) ? 4'(ent[ent.size()-1]) : 4'd0;
  endfunction

  function automatic void model_key(input logic [3:0] k);
    if (k <= 4'd9) begin
      if (ent.size() < 2) begin ent.push_back(int'(k)); refresh(); end
    end else if (k == 4'hF) begin
      if (ent.size() > 0) begin
        exp_loads++;
        exp_ld_ten  = (ent.size() == 2) ? 4'(ent[0]) : 4'd0;
        exp_ld_unit = 4'(ent[ent.size()-1]);
        ent.delete();
      end
    end else if (k == 4'hE) begin
      ent.delete(); refresh();
    end else if (k == 4'hB) begin
      if (ent.size() > 0) begin void'(ent.pop_back()); refresh(); end
    end
  endfunction

  int         kv_count = 0, load_count = 0;
  logic [3:0] cap_ten = 0, cap_unit = 0;
  logic       prev_kv = 0;

  always @(negedge CLK) begin
    if (Reset) begin
      if (Key_valid) kv_count++;
      if (Load) begin
        load_count++;
        cap_ten  = Data_out_ten_digit;
        cap_unit = Data_out_unit_digit;
      end
      if (Key_valid || Load) chk("kv_load_exclusive", 32'(Key_valid & Load), 0);
      if (Key_valid) chk("kv_single_clock", 32'(prev_kv), 0);
      prev_kv = Key_valid;
    end else begin
      prev_kv = 1'b0;
    end
  end

  task automatic check_after_key();
    @(negedge CLK); #1;
    chk("ten_digit", Data_out_ten_digit, m_ten);
    chk("unit_digit", Data_out_unit_digit, m_unit);
    chk("digit_cnt", Digit_cnt, ent.size());
    chk("load_count", load_count, exp_loads);
    chk("load_ten", cap_ten, exp_ld_ten);
    chk("load_unit", cap_unit, exp_ld_unit);
  endtask

  task automatic wait_accept(input logic [3:0] code);
    bit seen = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge CLK);
      if (Key_valid === 1'b1) begin seen = 1; break; end
    end
    chk("key_accept_timeout", 32'(seen), 1);
    if (seen) begin
      chk("key_code", Key_code, code);
      exp_kv++;
      exp_code = code;
      model_key(code);
      check_after_key();
    end
  endtask

  task automatic release_all();
    sw = '0;
    repeat (4*FRAME) @(negedge CLK);
    #1;
    chk("kv_count", kv_count, exp_kv);
    chk("key_code_held", Key_code, exp_code);
  endtask

  task automatic press(input int r, input int c, input int hold_frames);
    sw[r*4+c] = 1'b1;
    wait_accept(kmap[r*4+c]);
    repeat (hold_frames*FRAME) @(negedge CLK);
    release_all();
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_row"}, Row, 4'b1110);
    chk({tag, "_ten"}, Data_out_ten_digit, 0);
    chk({tag, "_unit"}, Data_out_unit_digit, 0);
    chk({tag, "_load"}, Load, 0);
    chk({tag, "_cnt"}, Digit_cnt, 0);
    chk({tag, "_kv"}, Key_valid, 0);
    chk({tag, "_code"}, Key_code, 0);
  endtask

  initial begin
    logic [3:0] exp_row;
    repeat (3) @(negedge CLK);
    check_reset_outputs("reset");

    Reset = 1'b1;
    for (int i = 0; i < 4*FRAME; i++) begin
      exp_row = ~(4'b0001 << (i/4 % 4));
      chk("row_scan", Row, exp_row);
      @(negedge CLK);
    end
    #1;
    chk("idle_kv", kv_count, 0);
    chk("idle_load", load_count, 0);

    // "4","2","#" -> Load 4,2
    press(1, 0, 1);
    press(0, 1, 0);
    press(3, 2, 2);
    chk("load_42_ten", cap_ten, 4);
    chk("load_42_unit", cap_unit, 2);
    // "7","#", then "#" while empty
    press(2, 0, 0);
    press(3, 2, 0);
    press(3, 2, 1);
    chk("load_after_empty_hash", load_count, 2);
    // "1","2","3","B","*"
    press(0, 0, 0);
    press(0, 1, 0);
    press(0, 2, 0);
    press(1, 3, 0);
    press(3, 0, 0);

    // Bouncing "5" for several frames, then stable
    sw[5] = 1'b1;
    for (int i = 0; i < 6; i++) begin
      repeat (FRAME) @(negedge CLK);
      sw[5] = ~sw[5];
    end
    #1;
    chk("bounce_no_kv", kv_count, exp_kv);
    wait_accept(4'h5);
    release_all();
    press(3, 0, 0);

    for (int n = 0; n < 30; n++)
      press(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), int'($urandom_range(0, 2)));

    // Ghosted pair, then reset in the middle of a single-key debounce
    press(3, 0, 0);
    press(2, 2, 0);
    sw[0] = 1'b1;
    sw[6] = 1'b1;
    repeat (6*FRAME) @(negedge CLK);
    #1;
    chk("ghost_no_kv", kv_count, exp_kv);
    sw[6] = 1'b0;
    repeat (8) @(negedge CLK);
    Reset = 1'b0;
    #1;
    check_reset_outputs("midreset");
    sw = '0;
    ent.delete(); refresh(); exp_code = 0;
    repeat (3) @(negedge CLK);
    Reset = 1'b1;
    repeat (6*FRAME) @(negedge CLK);
    #1;
    chk("post_reset_kv", kv_count, exp_kv);
    chk("post_reset_load", load_count, exp_loads);
    chk("post_reset_cnt", Digit_cnt, 0);
    press(1, 1, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
